hvsync_gen: RTL and testbench
=============================

HVSYNC_GEN -- requirements
Module: hvsync_gen

Interface
REQ-001 Parameter H_VIS, default 640, visible pixels per line.
REQ-002 Parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, default 96, hsync pulse width in pixels.
REQ-004 Parameter H_BP, default 48, horizontal back porch; H_TOTAL = sum of H_* = 800.
REQ-005 Parameters V_VIS/V_FP/V_SYNC/V_BP, defaults 480/10/2/33; V_TOTAL = 525.
REQ-006 Parameter SYNC_POL, default 0, active level of hsync/vsync.
REQ-007 clk  in  1  system clock, 2x pixel rate.
REQ-008 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-009 pix_en  out  1  one-clk pixel strobe (clk_div rising-edge equivalent).
REQ-010 hpos  out  10  current horizontal pixel counter, 0..H_TOTAL-1.
REQ-011 vpos  out  10  current line counter, 0..V_TOTAL-1.
REQ-012 hsync  out  1  horizontal sync, level SYNC_POL when active.
REQ-013 vsync  out  1  vertical sync, level SYNC_POL when active.
REQ-014 display_on  out  1  high when hpos < H_VIS and vpos < V_VIS.
REQ-015 frame_start  out  1  one-clk pulse in the clk where counters wrap to (0,0).

Function
REQ-016 Divider bit div SHALL toggle every clk; pix_en SHALL be registered high exactly in the clk following each clk where div = 1, giving period 2 clk, duty one clk.
REQ-017 hpos SHALL increment on each clk with pix_en = 1; at H_TOTAL-1 it SHALL wrap to 0 on the same strobe.
REQ-018 vpos SHALL increment only on the strobe where hpos wraps; at V_TOTAL-1 it SHALL wrap to 0 on that strobe.
REQ-019 Counters and all decoded outputs SHALL hold between strobes; no output changes in a clk without pix_en.
REQ-020 hsync SHALL be registered and equal SYNC_POL iff the new hpos lies in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC-1] (656..751 default), aligned to the same clk as hpos.
REQ-021 vsync SHALL be registered and equal SYNC_POL iff the new vpos lies in [V_VIS+V_FP, V_VIS+V_FP+V_SYNC-1] (490..491 default), aligned with vpos.
REQ-022 display_on SHALL be registered and aligned with hpos/vpos (zero relative latency).
REQ-023 frame_start SHALL assert for exactly one clk, coincident with the update to (0,0); never more than once per H_TOTAL*V_TOTAL strobes.
REQ-024 Frame period SHALL be H_TOTAL*V_TOTAL*2 = 840000 clk at defaults.
REQ-025 All counter arithmetic SHALL be 10-bit unsigned; compare-before-increment, no overflow past TOTAL-1.

Reset
REQ-026 While reset = 0: div = 0, pix_en = 0, hpos = 0, vpos = 0, hsync = vsync = ~SYNC_POL, display_on = 0, frame_start = 0.
REQ-027 First pix_en SHALL occur on the 2nd rising clk after reset deasserts; on it counters go to (1,0), display_on = 1; pixel (0,0) of the first frame is blanked.
REQ-028 Reset asserted mid-frame SHALL force reset values immediately (asynchronously) with no partial sync pulse continuing.

Structure
REQ-029 A shared package vga_timing_pkg SHALL hold the default H_*/V_* constants, H_TOTAL/V_TOTAL and the 10-bit position typedef.
REQ-030 The divider/strobe logic SHALL be a sub-module pix_tick_gen (ports clk, reset, pix_en); counters and decode stay in hvsync_gen.

Verification
REQ-031 Release reset after 7 clk -> first pix_en 2 clk later, then every 2 clk; hpos=1, vpos=0, display_on=1.
REQ-032 Run one line -> hsync = SYNC_POL exactly for hpos 656..751 (96 strobes = 192 clk); display_on low for hpos 640..799.
REQ-033 Run one frame -> vsync active for vpos 490..491 (1600 strobes); frame_start pulses exactly once, spacing 840000 clk.
REQ-034 At hpos=799, vpos=524 next strobe -> hpos=0, vpos=0, frame_start=1 for one clk, display_on=1.
REQ-035 Assert reset at hpos=700, vpos=490 -> within same clk hsync=vsync=1, counters 0, pix_en 0; after release timing restarts per REQ-027.
REQ-036 Capture display_on-gated pixels for 40 frames -> each frame exactly 640x480 visible samples, 800x525 total strobes.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480 timing defaults, position type and window-decode helper
// used by the sync generator.
package vga_timing_pkg;

   localparam int POS_W = 10;
   typedef logic [POS_W-1:0] pos_t;

   localparam int VGA_H_VIS   = 640;
   localparam int VGA_H_FP    = 16;
   localparam int VGA_H_SYNC  = 96;
   localparam int VGA_H_BP    = 48;
   localparam int VGA_H_TOTAL = VGA_H_VIS + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

   localparam int VGA_V_VIS   = 480;
   localparam int VGA_V_FP    = 10;
   localparam int VGA_V_SYNC  = 2;
   localparam int VGA_V_BP    = 33;
   localparam int VGA_V_TOTAL = VGA_V_VIS + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

   function automatic logic in_window(input pos_t p, input pos_t lo, input pos_t hi);
      return (p >= lo) && (p <= hi);
   endfunction

endpackage

// File: rtl/pix_tick_gen.sv
// Divides clk by two into a registered one-clk pixel strobe.
module pix_tick_gen (
   input  logic clk,
   input  logic reset,
   output logic pix_en
);

   logic div;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div    <= 1'b0;
         pix_en <= 1'b0;
      end else begin
         div    <= ~div;
         pix_en <= div;
      end
   end

endmodule

// File: rtl/hvsync_gen.sv
// VGA sync generator: pixel/line counters with registered sync, blanking
// and frame-start decode, all updated together with the pixel strobe.
module hvsync_gen
   import vga_timing_pkg::*;
#(
   parameter int   H_VIS    = VGA_H_VIS,
   parameter int   H_FP     = VGA_H_FP,
   parameter int   H_SYNC   = VGA_H_SYNC,
   parameter int   H_BP     = VGA_H_BP,
   parameter int   V_VIS    = VGA_V_VIS,
   parameter int   V_FP     = VGA_V_FP,
   parameter int   V_SYNC   = VGA_V_SYNC,
   parameter int   V_BP     = VGA_V_BP,
   parameter logic SYNC_POL = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   output logic             pix_en,
   output logic [POS_W-1:0] hpos,
   output logic [POS_W-1:0] vpos,
   output logic             hsync,
   output logic             vsync,
   output logic             display_on,
   output logic             frame_start
);

   localparam int   H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int   V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;
   localparam pos_t H_LAST   = pos_t'(H_TOTAL - 1);
   localparam pos_t V_LAST   = pos_t'(V_TOTAL - 1);
   localparam pos_t H_VIS_P  = pos_t'(H_VIS);
   localparam pos_t V_VIS_P  = pos_t'(V_VIS);
   localparam pos_t HS_FIRST = pos_t'(H_VIS + H_FP);
   localparam pos_t HS_LAST  = pos_t'(H_VIS + H_FP + H_SYNC - 1);
   localparam pos_t VS_FIRST = pos_t'(V_VIS + V_FP);
   localparam pos_t VS_LAST  = pos_t'(V_VIS + V_FP + V_SYNC - 1);

   logic armed;
   logic advance;
   pos_t hpos_nx;
   pos_t vpos_nx;

   pix_tick_gen u_tick (
      .clk    (clk),
      .reset  (reset),
      .pix_en (pix_en)
   );

   // pix_en is itself registered, so the counters advance on the edge that raises
   // it: every clk where pix_en is low, once the divider has left reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) armed <= 1'b0;
      else        armed <= 1'b1;
   end

   assign advance = armed & ~pix_en;

   always_comb begin
      hpos_nx = hpos;
      vpos_nx = vpos;
      if (hpos == H_LAST) begin
         hpos_nx = '0;
         if (vpos == V_LAST) vpos_nx = '0;
         else                vpos_nx = vpos + 10'd1;
      end else begin
         hpos_nx = hpos + 10'd1;
      end
   end

   // Decode from the next position so outputs line up with the counters.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hpos        <= '0;
         vpos        <= '0;
         hsync       <= ~SYNC_POL;
         vsync       <= ~SYNC_POL;
         display_on  <= 1'b0;
         frame_start <= 1'b0;
      end else if (advance) begin
         hpos        <= hpos_nx;
         vpos        <= vpos_nx;
         hsync       <= in_window(hpos_nx, HS_FIRST, HS_LAST) ? SYNC_POL : ~SYNC_POL;
         vsync       <= in_window(vpos_nx, VS_FIRST, VS_LAST) ? SYNC_POL : ~SYNC_POL;
         display_on  <= (hpos_nx < H_VIS_P) && (vpos_nx < V_VIS_P);
         frame_start <= (hpos_nx == '0) && (vpos_nx == '0);
      end else begin
         frame_start <= 1'b0;
      end
   end

endmodule

// File: tb/tb_hvsync_gen.sv
// Bench for hvsync_gen: one default-timing instance and one shrunken-geometry
// instance (active-high sync) so whole frames fit in a short run.
module tb_hvsync_gen;

   localparam int SHV = 8, SHF = 2, SHS = 3, SHB = 2;
   localparam int SVV = 4, SVF = 1, SVS = 2, SVB = 1;

   typedef struct packed {
      logic [9:0] h;
      logic [9:0] v;
      logic       hs;
      logic       vs;
      logic       de;
      logic       fs;
   } obs_t;

   logic       clk = 1'b0;
   logic       reset_d = 1'b0;
   logic       reset_s = 1'b0;
   logic       pix_en_d, hsync_d, vsync_d, de_d, fs_d;
   logic       pix_en_s, hsync_s, vsync_s, de_s, fs_s;
   logic [9:0] hpos_d, vpos_d, hpos_s, vpos_s;

   always #5 clk = ~clk;

   hvsync_gen dut_d (
      .clk(clk), .reset(reset_d), .pix_en(pix_en_d), .hpos(hpos_d), .vpos(vpos_d),
      .hsync(hsync_d), .vsync(vsync_d), .display_on(de_d), .frame_start(fs_d)
   );

   hvsync_gen #(
      .H_VIS(SHV), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
      .V_VIS(SVV), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB), .SYNC_POL(1'b1)
   ) dut_s (
      .clk(clk), .reset(reset_s), .pix_en(pix_en_s), .hpos(hpos_s), .vpos(vpos_s),
      .hsync(hsync_s), .vsync(vsync_s), .display_on(de_s), .frame_start(fs_s)
   );

   int   checks = 0;
   int   errors = 0;
   obs_t q_d[$];
   obs_t q_s[$];
   bit   sb_d = 1'b0;
   bit   sb_s = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cmp_obs(input string tag, input obs_t a, input obs_t e);
      check({tag, ".hpos"}, a.h, e.h);
      check({tag, ".vpos"}, a.v, e.v);
      check({tag, ".hsync"}, a.hs, e.hs);
      check({tag, ".vsync"}, a.vs, e.vs);
      check({tag, ".display_on"}, a.de, e.de);
      check({tag, ".frame_start"}, a.fs, e.fs);
   endtask

   // State shown at the k-th strobe after reset release, from the strobe index alone.
   function automatic obs_t model(input int k, input int hv, input int hf, input int hs,
                                  input int hb, input int vv, input int vf, input int vs,
                                  input int vb, input logic pol);
      int   ht, vt, h, v;
      obs_t o;
      ht   = hv + hf + hs + hb;
      vt   = vv + vf + vs + vb;
      h    = k % ht;
      v    = (k / ht) % vt;
      o.h  = 10'(h);
      o.v  = 10'(v);
      o.hs = (h >= hv + hf && h < hv + hf + hs) ? pol : ~pol;
      o.vs = (v >= vv + vf && v < vv + vf + vs) ? pol : ~pol;
      o.de = (h < hv) && (v < vv);
      o.fs = (h == 0) && (v == 0);
      return o;
   endfunction

   // Hand-picked points on line 1 of the default timing.
   function automatic bit dir_vec(input logic [9:0] h, output logic hs, output logic de);
      dir_vec = 1'b1;
      hs      = 1'b1;
      de      = 1'b0;
      case (h)
         10'd0:   begin hs = 1'b1; de = 1'b1; end
         10'd639: begin hs = 1'b1; de = 1'b1; end
         10'd640: begin hs = 1'b1; de = 1'b0; end
         10'd655: begin hs = 1'b1; de = 1'b0; end
         10'd656: begin hs = 1'b0; de = 1'b0; end
         10'd751: begin hs = 1'b0; de = 1'b0; end
         10'd752: begin hs = 1'b1; de = 1'b0; end
         10'd799: begin hs = 1'b1; de = 1'b0; end
         default: dir_vec = 1'b0;
      endcase
   endfunction

   int clk_cnt = 0;
   always @(posedge clk) clk_cnt <= clk_cnt + 1;

   obs_t cur_d, prev_d, cur_s, prev_s;
   logic pe_prev_d = 1'b0, pe_prev_s = 1'b0;
   int   hs_line1 = 0, de_line1 = 0;
   int   last_fs = -1, frames_s = 0, strobes_s = 0, visible_s = 0;

   always @(negedge clk) begin
      logic dhs, dde;
      cur_d = '{h: hpos_d, v: vpos_d, hs: hsync_d, vs: vsync_d, de: de_d, fs: fs_d};
      if (sb_d) begin
         check("d.pix_en_toggle", pix_en_d, !pe_prev_d);
         if (pix_en_d) begin
            if (q_d.size() == 0) begin
               checks++; errors++;
               $display("FAIL d.extra_strobe: strobe with no expectation at %0t", $time);
            end else begin
               cmp_obs("d", cur_d, q_d.pop_front());
            end
            if (vpos_d == 10'd1) begin
               if (dir_vec(hpos_d, dhs, dde)) begin
                  check("d.dir_hsync", hsync_d, dhs);
                  check("d.dir_display_on", de_d, dde);
               end
               if (hsync_d == 1'b0) hs_line1++;
               if (de_d) de_line1++;
            end
         end else begin
            check("d.hold", cur_d[23:1], prev_d[23:1]);
            check("d.fs_width", fs_d, 0);
         end
      end
      prev_d    = cur_d;
      pe_prev_d = pix_en_d;
   end

   always @(negedge clk) begin
      cur_s = '{h: hpos_s, v: vpos_s, hs: hsync_s, vs: vsync_s, de: de_s, fs: fs_s};
      if (sb_s) begin
         check("s.pix_en_toggle", pix_en_s, !pe_prev_s);
         if (pix_en_s) begin
            if (q_s.size() == 0) begin
               checks++; errors++;
               $display("FAIL s.extra_strobe: strobe with no expectation at %0t", $time);
            end else begin
               cmp_obs("s", cur_s, q_s.pop_front());
            end
            if (fs_s) begin
               check("s.fs_hpos", hpos_s, 0);
               check("s.fs_vpos", vpos_s, 0);
               check("s.fs_display_on", de_s, 1);
               if (last_fs >= 0) begin
                  check("s.frame_clks", clk_cnt - last_fs, 240);
                  check("s.frame_strobes", strobes_s, 120);
                  check("s.frame_visible", visible_s, 32);
                  frames_s++;
               end
               last_fs   = clk_cnt;
               strobes_s = 0;
               visible_s = 0;
            end
            strobes_s++;
            if (de_s) visible_s++;
         end else begin
            check("s.hold", cur_s[23:1], prev_s[23:1]);
            check("s.fs_width", fs_s, 0);
         end
      end
      prev_s    = cur_s;
      pe_prev_s = pix_en_s;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: run did not complete, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (7) @(negedge clk);
      #1;
      check("d.rst_pix_en", pix_en_d, 0);
      check("d.rst_hpos", hpos_d, 0);
      check("d.rst_vpos", vpos_d, 0);
      check("d.rst_hsync", hsync_d, 1);
      check("d.rst_vsync", vsync_d, 1);
      check("d.rst_display_on", de_d, 0);
      check("d.rst_frame_start", fs_d, 0);
      check("s.rst_pix_en", pix_en_s, 0);
      check("s.rst_hsync", hsync_s, 0);
      check("s.rst_vsync", vsync_s, 0);

      for (int k = 1; k <= 1610; k++)
         q_d.push_back(model(k, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0));
      for (int k = 1; k <= 446; k++)
         q_s.push_back(model(k, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB, 1'b1));

      @(negedge clk);
      reset_d = 1'b1;
      reset_s = 1'b1;
      @(negedge clk); #1;
      check("d.first_pix_en_early", pix_en_d, 0);
      check("d.hpos_before_strobe", hpos_d, 0);
      check("s.first_pix_en_early", pix_en_s, 0);
      sb_d = 1'b1;
      sb_s = 1'b1;
      @(negedge clk); #1;
      check("d.first_pix_en", pix_en_d, 1);
      check("d.first_hpos", hpos_d, 1);
      check("d.first_vpos", vpos_d, 0);
      check("d.first_display_on", de_d, 1);

      fork
         begin
            for (int i = 0; i < 4000 && q_d.size() != 0; i++) begin
               @(negedge clk); #1;
            end
            check("d.drain_left", q_d.size(), 0);
            sb_d = 1'b0;
            check("d.line1_hsync_strobes", hs_line1, 96);
            check("d.line1_visible_strobes", de_line1, 640);
         end
         begin
            for (int i = 0; i < 1500 && q_s.size() != 0; i++) begin
               @(negedge clk); #1;
            end
            check("s.drain1_left", q_s.size(), 0);
            check("s.pre_rst_hpos", hpos_s, 11);
            check("s.pre_rst_vpos", vpos_s, 5);
            check("s.pre_rst_hsync", hsync_s, 1);
            check("s.pre_rst_vsync", vsync_s, 1);
            #1;
            sb_s    = 1'b0;
            reset_s = 1'b0;
            #1;
            check("s.async_pix_en", pix_en_s, 0);
            check("s.async_hpos", hpos_s, 0);
            check("s.async_vpos", vpos_s, 0);
            check("s.async_hsync", hsync_s, 0);
            check("s.async_vsync", vsync_s, 0);
            check("s.async_display_on", de_s, 0);
            check("s.async_frame_start", fs_s, 0);
            @(negedge clk);
            @(negedge clk);
            q_s.delete();
            last_fs  = -1;
            frames_s = 0;
            for (int k = 1; k <= 42 * 120; k++)
               q_s.push_back(model(k, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB, 1'b1));
            reset_s = 1'b1;
            @(negedge clk); #1;
            check("s.restart_pix_en_early", pix_en_s, 0);
            sb_s = 1'b1;
            @(negedge clk); #1;
            check("s.restart_pix_en", pix_en_s, 1);
            check("s.restart_hpos", hpos_s, 1);
            check("s.restart_vpos", vpos_s, 0);
            check("s.restart_display_on", de_s, 1);
            for (int i = 0; i < 12000 && q_s.size() != 0; i++) begin
               @(negedge clk); #1;
            end
            check("s.drain2_left", q_s.size(), 0);
            sb_s = 1'b0;
            check("s.frames_measured", frames_s, 41);
         end
      join

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
